// File: rtl/mac_result_fifo.sv
// First-word-fall-through result buffer behind the multiply-add unit.
// Upstream cannot be stalled, so a push into a full FIFO is dropped and recorded.
module mac_result_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 8
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       valido,
   input  logic [DW-1:0]              data_out,
   output logic                       out_valid,
   output logic [DW-1:0]              out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [CW-1:0]              drop_cnt,
   input  logic                       clr_ovf
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

   logic push, pop, drop;

   // Status and head presentation come straight from registered state.
   assign count     = count_q;
   assign full      = (count_q == CNTW'(DEPTH));
   assign empty     = (count_q == CNTW'(0));
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

   always_comb begin
      pop        = out_valid && out_ready;
      push       = valido && (!full || pop);
      drop       = valido && full && !pop;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = data_out;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNTW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNTW'(1);
      end

      // A drop in the same cycle as a clear restarts the record at one.
      if (clr_ovf) begin
         overflow_d = drop;
         drop_cnt_d = drop ? CW'(1) : CW'(0);
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {CW{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Scoreboard bench for mac_result_fifo: directed stimulus queues expected words,
// a negedge monitor checks every handshake plus the output invariants.
module tb_mac_result_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 8;

   logic          clk = 1'b0;
   logic          rst_;
   logic          valido;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [2:0]    count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [CW-1:0] drop_cnt;
   logic          clr_ovf;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] sb[$];
   int            m_cnt  = 0;
   logic          m_ovf  = 1'b0;
   int            m_drop = 0;

   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   mac_result_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst_(rst_), .valido(valido), .data_out(data_out),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count), .full(full), .empty(empty), .overflow(overflow),
      .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks invariants.
   always @(negedge clk) begin
      if (rst_ === 1'b1) begin
         if (full && empty) begin
            checks++; errors++;
            $display("FAIL inv_full_empty: got full=1 empty=1 expected not both");
         end
         if (count > 3'(DEPTH)) begin
            checks++; errors++;
            $display("FAIL inv_count: got %0d expected <= %0d", count, DEPTH);
         end
         if (prev_hold && out_valid) check("hold_stable", 64'(out_data), 64'(prev_data));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
            end else begin
               check("sb_data", 64'(out_data), 64'(sb.pop_front()));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end else begin
         prev_hold = 1'b0;
      end
   end

   // Apply one cycle of inputs, update the reference model, advance past the edge.
   task automatic tick(input logic v, input logic [DW-1:0] d, input logic rdy,
                       input logic clr, input logic rst_n);
      logic m_pop, m_push, m_drp;
      valido = v; data_out = d; out_ready = rdy; clr_ovf = clr; rst_ = rst_n;
      m_pop  = (m_cnt != 0) && rdy;
      m_push = v && ((m_cnt != DEPTH) || m_pop);
      m_drp  = v && (m_cnt == DEPTH) && !m_pop;
      if (!rst_n) begin
         m_cnt = 0; m_ovf = 1'b0; m_drop = 0; sb.delete();
      end else begin
         if (m_push) sb.push_back(d);
         m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
         if (clr) begin
            m_ovf = m_drp; m_drop = m_drp ? 1 : 0;
         end else if (m_drp) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
         end
      end
      @(posedge clk);
      #1;
      valido = 1'b0; clr_ovf = 1'b0; rst_ = 1'b1; data_out = '0;
   endtask

   task automatic check_model(input string name);
      check({name, "_count"}, 64'(count), 64'(m_cnt));
      check({name, "_ovf"}, 64'(overflow), 64'(m_ovf));
      check({name, "_drop"}, 64'(drop_cnt), 64'(m_drop));
   endtask

   initial begin
      rst_ = 1'b0; valido = 1'b0; data_out = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         check("rst_valid", 64'(out_valid), 64'd0);
         check("rst_data", 64'(out_data), 64'd0);
         check("rst_empty", 64'(empty), 64'd1);
         check("rst_full", 64'(full), 64'd0);
         check("rst_count", 64'(count), 64'd0);
         check("rst_ovf", 64'(overflow), 64'd0);
         check("rst_drop", 64'(drop_cnt), 64'd0);
         tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
      end

      // Single result, held, then consumed; ready while empty is ignored
      check("empty_ready_valid", 64'(out_valid), 64'd0);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("empty_ready_count", 64'(count), 64'd0);
      tick(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("one_valid", 64'(out_valid), 64'd1);
         check("one_data", 64'(out_data), 64'h13);
         check("one_count", 64'(count), 64'd1);
         if (i < 3) tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("one_empty", 64'(empty), 64'd1);
      check("one_data0", 64'(out_data), 64'd0);

      // Fill, overflow, drain in order
      for (int i = 1; i <= 4; i++) tick(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
      check("fill_full", 64'(full), 64'd1);
      check("fill_count", 64'(count), 64'd4);
      check("fill_head", 64'(out_data), 64'd1);
      tick(1'b1, 32'd5, 1'b0, 1'b0, 1'b1);
      check("drop_ovf", 64'(overflow), 64'd1);
      check("drop_cnt1", 64'(drop_cnt), 64'd1);
      check("drop_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_sb", 64'(sb.size()), 64'd0);

      // Push and pop together while full: no drop
      for (int i = 1; i <= 4; i++) tick(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'd9, 1'b1, 1'b0, 1'b1);
      check("pp_count", 64'(count), 64'd4);
      check("pp_drop", 64'(drop_cnt), 64'd1);
      check("pp_head", 64'(out_data), 64'd2);
      check_model("pp");
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("pp_empty", 64'(empty), 64'd1);

      // Push and pop together at count==1
      tick(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'hA2, 1'b1, 1'b0, 1'b1);
      check("c1_valid", 64'(out_valid), 64'd1);
      check("c1_data", 64'(out_data), 64'hA2);
      check("c1_count", 64'(count), 64'd1);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Saturating drop counter, then clear coincident with a drop
      for (int i = 1; i <= 4; i++) tick(1'b1, DW'(16 + i), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) tick(1'b1, 32'hDEAD_0000 + DW'(i), 1'b0, 1'b0, 1'b1);
      check("sat_drop", 64'(drop_cnt), 64'd255);
      check("sat_ovf", 64'(overflow), 64'd1);
      tick(1'b1, 32'hBAD, 1'b0, 1'b1, 1'b1);
      check("clrdrop_ovf", 64'(overflow), 64'd1);
      check("clrdrop_cnt", 64'(drop_cnt), 64'd1);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("clr_ovf", 64'(overflow), 64'd0);
      check("clr_cnt", 64'(drop_cnt), 64'd0);
      check("clr_count", 64'(count), 64'd4);
      check_model("clr");
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("sat_drain_empty", 64'(empty), 64'd1);

      // Reset mid-operation with a coincident push
      for (int i = 1; i <= 3; i++) tick(1'b1, DW'(32 + i), 1'b0, 1'b0, 1'b1);
      check("pre_rst_count", 64'(count), 64'd3);
      tick(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_empty", 64'(empty), 64'd1);
      check("mid_rst_data", 64'(out_data), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("post_rst_count", 64'(count), 64'd0);
      check_model("end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
- Downstream stage of the 3-cycle multiply-add unit. Captures each result presented with valido/data_out and buffers it in a small FIFO.
- Re-presents results to the next consumer over a valid/ready handshake.
- The upstream unit has no back-pressure, so a push into a full FIFO drops the result. Drops are recorded in a sticky flag and a saturating counter.

Parameters:
- DW, 32, data width; must match the upstream data_out width.
- DEPTH, 4, number of FIFO entries; must be a power of two, ≥ 2.
- CW, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst_  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- valido  in  1  upstream result valid; a single-cycle pulse per result.
- data_out  in  DW  upstream result, qualified by valido.
- out_valid  out  1  head entry available.
- out_data  out  DW  head entry; driven to 0 when empty.
- out_ready  in  1  consumer accepts the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when a result is dropped.
- drop_cnt  out  CW  number of dropped results; saturates at 2^CW-1.
- clr_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- Reset (rst_==0 at posedge): count=0, rd/wr pointers=0, out_valid=0, out_data=0, full=0, empty=1, overflow=0, drop_cnt=0.
  - Reset overrides every other input in that cycle.
  - Reset mid-operation discards all stored entries.
- push = valido && (!full || pop).
- pop = out_valid && out_ready.
  - out_ready while empty is ignored.
- Organisation: first-word-fall-through.
  - out_valid = !empty; out_data = mem[rd_ptr] when !empty, else 0. Both are combinational from registered state.
  - Push-to-out_valid latency is 1 cycle; there is no same-cycle bypass when empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Simultaneous push and pop when full:
  - Both occur; the new word is written to the slot freed by the head.
  - count stays DEPTH; no drop.
- Simultaneous push and pop when count==1:
  - The head is consumed and the new word becomes the head next cycle.
  - out_valid stays 1.
- Drop: valido && full && !pop.
  - data_out is discarded; memory and pointers are unchanged.
  - overflow=1 next cycle.
  - drop_cnt increments next cycle, holding at 2^CW-1.
- clr_ovf:
  - Alone: overflow=0 and drop_cnt=0 next cycle.
  - Coincident with a drop: overflow=1, drop_cnt=1.
  - clr_ovf does not affect FIFO contents.
- data_out is sampled only when push is true; its value is don't-care otherwise.
- Invariants for the bench:
  - full && empty never both 1.
  - count ≤ DEPTH.
  - out_data stable while out_valid && !out_ready.
  - Data leaves in push order with no duplication.

Test Plan:
- Reset, then idle -> out_valid=0, out_data=0, empty=1, count=0, overflow=0, drop_cnt=0 for 5 cycles.
- One valido pulse with data_out=0x0000_0013, out_ready=0 -> next cycle out_valid=1, out_data=0x13, count=1. Hold 3 cycles unchanged; then out_ready=1 for 1 cycle -> empty=1 next cycle.
- Push 1,2,3,4 with out_ready=0 -> full=1, count=4. Push 5 -> overflow=1, drop_cnt=1. Drain -> reads 1,2,3,4 in order, then empty.
- While full, valido with data 9 and out_ready=1 in the same cycle -> count stays 4, no drop. Drain yields 2,3,4,9.
- With FIFO full, 300 further pushes and out_ready=0 -> drop_cnt=255. Pulse clr_ovf coincident with one more drop -> overflow=1, drop_cnt=1.
- Fill to 3 entries, assert rst_=0 for 1 cycle alongside valido -> count=0, empty=1, out_data=0; the coincident valido is not stored.
